slh_chain_master: RTL and testbench

- Bus-master sequencer that drives the 32-bit memory-mapped Keccak/SLH-DSA F-chain accelerator.
- Takes one WOTS+/FORS job as parallel operands: n, steps s, PRF flag, PK.seed, ADRS, SK.seed, message.
- Loads the operands into the accelerator, arms the chain, waits for its completion irq, then reads back the n-byte result.
- Sits directly upstream of the accelerator and replaces CPU polling in the SLH-DSA datapath.

---
 rtl/slh_kecc_pkg.sv | 45 ++++
 rtl/slh_chain_master.sv | 165 ++++++++++++++++
 tb/tb_slh_chain_master.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/slh_kecc_pkg.sv
// Shared definitions for the SLH-DSA F-chain accelerator master: register map,
// CHNS flag bits, sequencer states and operand helpers.
package slh_kecc_pkg;

    localparam logic [6:0] ADDR_MEMA = 7'd0;
    localparam logic [6:0] ADDR_ADRS = 7'd50;
    localparam logic [6:0] ADDR_SEED = 7'd58;
    localparam logic [6:0] ADDR_SKSD = 7'd66;
    localparam logic [6:0] ADDR_SECN = 7'd122;
    localparam logic [6:0] ADDR_CHNS = 7'd123;

    localparam logic [7:0] CHNS_PRF = 8'h40;
    localparam logic [7:0] CHNS_PAD = 8'h80;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_SEED,
        ST_WR_ADRS,
        ST_WR_DATA,
        ST_WR_SECN,
        ST_WR_CHNS,
        ST_WAIT,
        ST_RD,
        ST_DONE
    } state_t;

    function automatic logic n_legal(input logic [7:0] n);
        return (n == 8'd16) || (n == 8'd24) || (n == 8'd32);
    endfunction

    // Step count occupies the low bits; the flag bits are never driven by s.
    function automatic logic [7:0] chns_byte(input logic prf, input logic [5:0] s);
        return ({2'b00, s} & ~(CHNS_PRF | CHNS_PAD)) | (prf ? CHNS_PRF : 8'h00);
    endfunction

    function automatic logic [255:0] byte_mask(input logic [7:0] n);
        logic [255:0] m;
        m = '0;
        for (int unsigned k = 0; k < 32; k++) begin
            if (k < 32'(n)) m[8*k +: 8] = 8'hFF;
        end
        return m;
    endfunction

endpackage

// File: rtl/slh_chain_master.sv
// Bus-master sequencer: loads one WOTS+/FORS chain job into the Keccak F-chain
// accelerator, waits for its irq (bounded by TIMEOUT) and reads back n bytes.
module slh_chain_master
    import slh_kecc_pkg::*;
#(
    parameter int unsigned TIMEOUT = 2048,
    parameter int unsigned TW      = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [7:0]   n_i,
    input  logic [5:0]   s_i,
    input  logic         prf_i,
    input  logic [255:0] seed_i,
    input  logic [255:0] adrs_i,
    input  logic [255:0] sksd_i,
    input  logic [255:0] msg_i,
    output logic         busy_o,
    output logic         done_o,
    output logic         err_o,
    output logic [255:0] res_o,
    output logic         kc_sel,
    output logic [3:0]   kc_wen,
    output logic [6:0]   kc_addr,
    output logic [31:0]  kc_wdata,
    input  logic [31:0]  kc_rdata,
    input  logic         kc_irq
);

    state_t          state_q, state_d;
    logic [3:0]      idx_q;
    logic [TW-1:0]   tmo_q;
    logic [7:0]      n_q;
    logic [5:0]      s_q;
    logic            prf_q;
    logic [255:0]    seed_q, adrs_q, sksd_q, msg_q;
    logic [255:0]    res_q;
    logic            err_q;
    logic [3:0]      rd_words;

    function automatic logic [31:0] word_of(input logic [255:0] v, input logic [2:0] i);
        return v[{i, 5'b00000} +: 32];
    endfunction

    assign rd_words = n_q[5:2];
    assign busy_o   = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done_o   = (state_q == ST_DONE);
    assign err_o    = err_q;
    assign res_o    = res_q;

    always_comb begin
        state_d  = state_q;
        kc_sel   = 1'b0;
        kc_wen   = '0;
        kc_addr  = '0;
        kc_wdata = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (!n_legal(n_i) || (s_i == 6'd0 && !prf_i)) state_d = ST_DONE;
                    else                                          state_d = ST_WR_SEED;
                end
            end
            ST_WR_SEED: begin
                kc_sel   = 1'b1;
                kc_wen   = '1;
                kc_addr  = ADDR_SEED + {4'b0000, idx_q[2:0]};
                kc_wdata = word_of(seed_q, idx_q[2:0]);
                if (idx_q[2:0] == 3'd7) state_d = ST_WR_ADRS;
            end
            ST_WR_ADRS: begin
                kc_sel   = 1'b1;
                kc_wen   = '1;
                kc_addr  = ADDR_ADRS + {4'b0000, idx_q[2:0]};
                kc_wdata = word_of(adrs_q, idx_q[2:0]);
                if (idx_q[2:0] == 3'd7) state_d = ST_WR_DATA;
            end
            ST_WR_DATA: begin
                kc_sel   = 1'b1;
                kc_wen   = '1;
                kc_addr  = (prf_q ? ADDR_SKSD : ADDR_MEMA) + {4'b0000, idx_q[2:0]};
                kc_wdata = word_of(prf_q ? sksd_q : msg_q, idx_q[2:0]);
                if (idx_q[2:0] == 3'd7) state_d = ST_WR_SECN;
            end
            ST_WR_SECN: begin
                kc_sel   = 1'b1;
                kc_wen   = '1;
                kc_addr  = ADDR_SECN;
                kc_wdata = {24'h000000, n_q};
                state_d  = ST_WR_CHNS;
            end
            ST_WR_CHNS: begin
                kc_sel   = 1'b1;
                kc_wen   = '1;
                kc_addr  = ADDR_CHNS;
                kc_wdata = {24'h000000, chns_byte(prf_q, s_q)};
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                if (kc_irq)                            state_d = ST_RD;
                else if (tmo_q == TW'(TIMEOUT - 1))    state_d = ST_DONE;
            end
            ST_RD: begin
                // Final cycle only captures the last read, so the bus is released.
                if (idx_q != rd_words) begin
                    kc_sel  = 1'b1;
                    kc_addr = ADDR_MEMA + {3'b000, idx_q};
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q  <= '0;
            tmo_q  <= '0;
            n_q    <= '0;
            s_q    <= '0;
            prf_q  <= 1'b0;
            seed_q <= '0;
            adrs_q <= '0;
            sksd_q <= '0;
            msg_q  <= '0;
            res_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            idx_q <= (state_d != state_q || state_q == ST_IDLE) ? '0 : idx_q + 4'd1;
            tmo_q <= (state_q == ST_WAIT) ? tmo_q + 1'b1 : '0;

            if (state_q == ST_IDLE && start) begin
                n_q    <= n_i;
                s_q    <= s_i;
                prf_q  <= prf_i;
                seed_q <= seed_i;
                adrs_q <= adrs_i;
                sksd_q <= sksd_i;
                msg_q  <= msg_i;
                err_q  <= !n_legal(n_i);
                res_q  <= (n_legal(n_i) && s_i == 6'd0 && !prf_i) ? (msg_i & byte_mask(n_i)) : '0;
            end

            if (state_q == ST_WAIT && state_d == ST_DONE) begin
                err_q <= 1'b1;
                res_q <= '0;
            end

            if (state_q == ST_RD) begin
                for (int unsigned k = 0; k < 8; k++) begin
                    if (idx_q == 4'(k + 1)) res_q[32*k +: 32] <= kc_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_slh_chain_master.sv
// Directed bench for slh_chain_master with a behavioural F-chain accelerator stub.
module tb_slh_chain_master;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [7:0]   n_i;
    logic [5:0]   s_i;
    logic         prf_i;
    logic [255:0] seed_i, adrs_i, sksd_i, msg_i;
    logic         busy_o, done_o, err_o;
    logic [255:0] res_o;
    logic         kc_sel;
    logic [3:0]   kc_wen;
    logic [6:0]   kc_addr;
    logic [31:0]  kc_wdata;
    logic [31:0]  kc_rdata;
    logic         kc_irq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    slh_chain_master #(.TIMEOUT(2048), .TW(12)) dut (
        .clk(clk), .rst(rst), .start(start), .n_i(n_i), .s_i(s_i), .prf_i(prf_i),
        .seed_i(seed_i), .adrs_i(adrs_i), .sksd_i(sksd_i), .msg_i(msg_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .res_o(res_o),
        .kc_sel(kc_sel), .kc_wen(kc_wen), .kc_addr(kc_addr), .kc_wdata(kc_wdata),
        .kc_rdata(kc_rdata), .kc_irq(kc_irq)
    );

    // Accelerator stub: 10 cycles after a CHNS write it mixes the loaded
    // registers into MEMA 0..7 and pulses irq (if enabled).
    logic [31:0] mem [0:127];
    logic        model_irq, stray_irq, irq_en, pend;
    int          dly;
    assign kc_irq = model_irq | stray_irq;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 128; i++) mem[i] <= '0;
            model_irq <= 1'b0;
            pend      <= 1'b0;
            dly       <= 0;
            kc_rdata  <= '0;
        end else begin
            model_irq <= 1'b0;
            if (kc_sel && kc_wen == 4'hF) begin
                mem[kc_addr] <= kc_wdata;
                if (kc_addr == 7'd123) begin
                    pend <= 1'b1;
                    dly  <= 10;
                end
            end
            if (kc_sel && kc_wen == 4'h0) kc_rdata <= mem[kc_addr];
            if (pend) begin
                if (dly == 0) begin
                    pend      <= 1'b0;
                    model_irq <= irq_en;
                    for (int i = 0; i < 8; i++)
                        mem[i] <= mem[58+i] ^ mem[50+i] ^ (mem[123][6] ? mem[66+i] : mem[i])
                                  ^ mem[123] ^ (mem[122] << 8);
                end else begin
                    dly <= dly - 1;
                end
            end
        end
    end

    int          wr_cnt = 0, rd_cnt = 0, done_cnt = 0;
    logic [6:0]  wr_addr_log [0:1023];
    logic [31:0] wr_data_log [0:1023];
    logic [6:0]  last_rd_addr = '0;

    always @(posedge clk) begin
        if (!rst) begin
            if (kc_sel && kc_wen == 4'hF) begin
                wr_addr_log[wr_cnt[9:0]] <= kc_addr;
                wr_data_log[wr_cnt[9:0]] <= kc_wdata;
                wr_cnt <= wr_cnt + 1;
            end
            if (kc_sel && kc_wen == 4'h0) begin
                rd_cnt       <= rd_cnt + 1;
                last_rd_addr <= kc_addr;
            end
            if (done_o) done_cnt <= done_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] mk(input logic [31:0] b);
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = b ^ (32'(i) * 32'h9E3779B9);
        return v;
    endfunction

    function automatic logic [255:0] exp_chain(input logic [7:0] n, input logic [5:0] s, input logic p,
                                               input logic [255:0] sd, input logic [255:0] ad,
                                               input logic [255:0] sk, input logic [255:0] ms);
        logic [255:0] r, d;
        logic [7:0]   ch;
        r  = '0;
        d  = p ? sk : ms;
        ch = p ? (8'h40 | {2'b00, s}) : {2'b00, s};
        for (int i = 0; i < int'(n) / 4; i++)
            r[32*i +: 32] = sd[32*i +: 32] ^ ad[32*i +: 32] ^ d[32*i +: 32]
                            ^ {24'h0, ch} ^ {16'h0, n, 8'h0};
        return r;
    endfunction

    function automatic logic [255:0] trunc_bytes(input logic [255:0] ms, input logic [7:0] n);
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < int'(n); i++) r[8*i +: 8] = ms[8*i +: 8];
        return r;
    endfunction

    task automatic kick(input logic [7:0] n, input logic [5:0] s, input logic p,
                        input logic [255:0] sd, input logic [255:0] ad,
                        input logic [255:0] sk, input logic [255:0] ms);
        @(negedge clk);
        n_i = n; s_i = s; prf_i = p;
        seed_i = sd; adrs_i = ad; sksd_i = sk; msg_i = ms;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_job(input string tag, input logic [7:0] n, input logic [5:0] s, input logic p,
                           input logic [255:0] sd, input logic [255:0] ad,
                           input logic [255:0] sk, input logic [255:0] ms,
                           input int exp_lat, input logic exp_err, input logic exp_bus,
                           input int dup_at, input int stray_at);
        int c, w0, r0, d0;
        logic [255:0] er;
        logic [7:0]   ch;
        w0 = wr_cnt; r0 = rd_cnt; d0 = done_cnt;
        kick(n, s, p, sd, ad, sk, ms);
        c = 1;
        if (exp_lat > 1) chk({tag, "_busy"}, 256'(busy_o), 256'(1));
        while (done_o !== 1'b1 && c < 3000) begin
            @(negedge clk);
            c++;
            start     = (c == dup_at);
            stray_irq = (c == stray_at);
            if (c == dup_at) begin
                n_i = 8'd20; msg_i = ~ms; seed_i = ~sd;
            end
        end
        start = 1'b0;
        stray_irq = 1'b0;

        er = exp_err ? '0 : (exp_bus ? exp_chain(n, s, p, sd, ad, sk, ms) : trunc_bytes(ms, n));
        ch = p ? (8'h40 | {2'b00, s}) : {2'b00, s};
        chk({tag, "_lat"},  256'(c),      256'(exp_lat));
        chk({tag, "_done"}, 256'(done_o), 256'(1));
        chk({tag, "_err"},  256'(err_o),  256'(exp_err));
        chk({tag, "_nbusy"}, 256'(busy_o), 256'(0));
        chk({tag, "_res"},  res_o, er);
        chk({tag, "_wrs"},  256'(wr_cnt - w0), 256'(exp_bus ? 26 : 0));
        chk({tag, "_rds"},  256'(rd_cnt - r0), 256'((exp_bus && !exp_err) ? int'(n) / 4 : 0));
        if (exp_bus && !exp_err)
            chk({tag, "_lastrd"}, 256'(last_rd_addr), 256'(int'(n) / 4 - 1));
        if (exp_bus) begin
            chk({tag, "_a_seed"}, {wr_addr_log[w0], wr_addr_log[w0+7]},   {7'd58, 7'd65});
            chk({tag, "_a_adrs"}, {wr_addr_log[w0+8], wr_addr_log[w0+15]}, {7'd50, 7'd57});
            chk({tag, "_a_data"}, {wr_addr_log[w0+16], wr_addr_log[w0+23]},
                p ? {7'd66, 7'd73} : {7'd0, 7'd7});
            chk({tag, "_a_ctl"},  {wr_addr_log[w0+24], wr_addr_log[w0+25]}, {7'd122, 7'd123});
            chk({tag, "_d_seed"}, 256'(wr_data_log[w0]), 256'(sd[31:0]));
            chk({tag, "_d_data"}, 256'(wr_data_log[w0+16]), 256'(p ? sk[31:0] : ms[31:0]));
            chk({tag, "_d_secn"}, 256'(wr_data_log[w0+24]), 256'({24'h0, n}));
            chk({tag, "_d_chns"}, 256'(wr_data_log[w0+25]), 256'({24'h0, ch}));
        end
        repeat (3) @(negedge clk);
        chk({tag, "_pulse"},   256'(done_o), 256'(0));
        chk({tag, "_ndone"},   256'(done_cnt - d0), 256'(1));
        chk({tag, "_reshold"}, res_o, er);
        chk({tag, "_errhold"}, 256'(err_o), 256'(exp_err));
    endtask

    logic [255:0] sd_a, ad_a, sk_a, ms_a;
    int           d0;

    initial begin
        rst = 1'b1; start = 1'b0; stray_irq = 1'b0; irq_en = 1'b1;
        n_i = '0; s_i = '0; prf_i = 1'b0;
        seed_i = '0; adrs_i = '0; sksd_i = '0; msg_i = '0;
        sd_a = mk(32'h5EED0001); ad_a = mk(32'hAD500002);
        sk_a = mk(32'h5C5D0003); ms_a = mk(32'h4D560004);
        repeat (3) @(negedge clk);
        chk("rst_outs", {busy_o, done_o, err_o, kc_sel, kc_wen, kc_addr, kc_wdata}, '0);
        chk("rst_res", res_o, '0);
        rst = 1'b0;

        // n=32 plain chain; a second start (with altered operands) while busy is ignored
        run_job("j32", 8'd32, 6'd1, 1'b0, sd_a, ad_a, sk_a, ms_a, 48, 1'b0, 1'b1, 5, 0);
        // n=16 with PRF
        run_job("j16p", 8'd16, 6'd3, 1'b1, ~sd_a, ad_a ^ 256'h1234, sk_a, ms_a, 44, 1'b0, 1'b1, 0, 0);
        // n=24 bypass
        run_job("byp24", 8'd24, 6'd0, 1'b0, sd_a, ad_a, sk_a, ~ms_a, 1, 1'b0, 1'b0, 0, 0);
        // illegal n
        run_job("n20", 8'd20, 6'd4, 1'b0, sd_a, ad_a, sk_a, ms_a, 1, 1'b1, 1'b0, 0, 0);
        repeat (5) @(negedge clk);
        chk("n20_errlong", 256'(err_o), 256'(1));

        // no irq: timeout; stray irq during WR_ADRS ignored
        irq_en = 1'b0;
        run_job("tmo", 8'd32, 6'd5, 1'b0, sd_a, ad_a, sk_a, ms_a, 2075, 1'b1, 1'b1, 0, 10);
        irq_en = 1'b1;

        // rst during WAIT
        d0 = done_cnt;
        kick(8'd32, 6'd2, 1'b0, sd_a, ad_a, sk_a, ms_a);
        repeat (29) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rstw_st", {busy_o, done_o, kc_sel, err_o}, '0);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        chk("rstw_nodone", 256'(done_cnt - d0), 256'(0));

        // rst during RD (RD spans cycles 39..47 after accept for n=32)
        d0 = done_cnt;
        kick(8'd32, 6'd2, 1'b0, sd_a, ad_a, sk_a, ms_a);
        repeat (40) @(negedge clk);
        chk("rstr_inrd", 256'(kc_sel), 256'(1));
        rst = 1'b1;
        @(negedge clk);
        chk("rstr_st", {busy_o, done_o, kc_sel, err_o}, '0);
        chk("rstr_res", res_o, '0);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        chk("rstr_nodone", 256'(done_cnt - d0), 256'(0));

        run_job("post", 8'd24, 6'd7, 1'b1, ~sd_a, ~ad_a, ~sk_a, ms_a, 46, 1'b0, 1'b1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
